// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick timer arbiter: FSM states, default
// prescale ratio and requester indices.
package tick_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned c_IFREQ_DEF = 12000000;
    localparam int unsigned c_TFREQ_DEF = 1000000;
    localparam int unsigned c_PRESC     = c_IFREQ_DEF / c_TFREQ_DEF;

    localparam logic c_REQ_UART = 1'b0;
    localparam logic c_REQ_DBUS = 1'b1;

    function automatic int unsigned presc_width(input int unsigned presc);
        return $clog2(presc);
    endfunction

    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == c_REQ_DBUS) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic req_other(input logic idx);
        return (idx == c_REQ_UART) ? c_REQ_DBUS : c_REQ_UART;
    endfunction

endpackage

// File: rtl/tick_timer_arbiter_prescaler.sv
// Prescaler for the shared timer: counts 0..c_DIV-1 while enabled and strobes
// on the last count. Synchronous clear has priority over enable.
module tick_prescaler
    import tick_timer_pkg::*;
#(
    parameter int unsigned c_DIV = c_PRESC
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_strobe
);

    localparam int unsigned     c_W    = presc_width(c_DIV);
    localparam logic [c_W-1:0]  c_LAST = c_W'(c_DIV - 1);

    logic [c_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + c_W'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_strobe = i_enable && (cnt_q == c_LAST);

endmodule

// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter in front of one prescaled down-counter timer shared by the
// UART (0) and D-bus (1) line FSMs; the owner gets a one-cycle o_done on expiry.
module tick_timer_arbiter
    import tick_timer_pkg::*;
#(
    parameter int unsigned c_IFREQ = c_IFREQ_DEF,
    parameter int unsigned c_TFREQ = c_TFREQ_DEF,
    parameter int unsigned c_CNTW  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [1:0]        i_req,
    input  logic [c_CNTW-1:0] i_len0,
    input  logic [c_CNTW-1:0] i_len1,
    output logic [1:0]        o_grant,
    output logic [1:0]        o_done,
    output logic              o_busy,
    output logic              o_tick
);

    localparam int unsigned c_DIV = c_IFREQ / c_TFREQ;

    state_e            state_q, state_d;
    logic [c_CNTW-1:0] cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic              busy_q;
    logic              presc_clear, presc_en, tick;
    logic              winner;
    logic [c_CNTW-1:0] win_len;
    logic              expire;

    tick_prescaler #(
        .c_DIV (c_DIV)
    ) u_prescaler (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (presc_clear),
        .i_enable  (presc_en),
        .o_strobe  (tick)
    );

    assign winner  = i_req[ptr_q] ? ptr_q : req_other(ptr_q);
    assign win_len = (winner == c_REQ_DBUS) ? i_len1 : i_len0;
    assign expire  = tick && (cnt_q == c_CNTW'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        done_d      = 2'b00;
        presc_clear = 1'b0;
        presc_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                presc_clear = 1'b1;
                grant_d     = 2'b00;
                if (|i_req) begin
                    owner_d = winner;
                    grant_d = req_onehot(winner);
                    cnt_d   = win_len;
                    if (win_len == '0) begin
                        state_d = StDone;
                        done_d  = req_onehot(winner);
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                presc_en = 1'b1;
                // Expiry beats a request drop landing on the same tick.
                if (expire) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    done_d  = req_onehot(owner_q);
                end else if (!i_req[owner_q]) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    grant_d = 2'b00;
                    ptr_d   = req_other(owner_q);
                end else if (tick) begin
                    cnt_d = cnt_q - c_CNTW'(1);
                end
            end
            StDone: begin
                presc_clear = 1'b1;
                state_d     = StIdle;
                grant_d     = 2'b00;
                ptr_d       = req_other(owner_q);
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= c_REQ_UART;
            ptr_q   <= c_REQ_UART;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign o_grant = grant_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_tick  = tick;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Bench for tick_timer_arbiter at a 4:1 prescale: a cycle-timeline model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_tick_timer_arbiter;

    localparam int P = 4;

    logic        i_clock   = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [1:0]  i_req     = 2'b00;
    logic [15:0] i_len0    = '0;
    logic [15:0] i_len1    = '0;
    logic [1:0]  o_grant, o_done;
    logic        o_busy, o_tick;

    int errors = 0;
    int checks = 0;

    always #5 i_clock = ~i_clock;

    tick_timer_arbiter #(
        .c_IFREQ (8),
        .c_TFREQ (2),
        .c_CNTW  (16)
    ) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .i_len0    (i_len0),
        .i_len1    (i_len1),
        .o_grant   (o_grant),
        .o_done    (o_done),
        .o_busy    (o_busy),
        .o_tick    (o_tick)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Timeline model: a grant decided in cycle n0 finishes in cycle n0+1+len*P.
    int cyc   = 0;
    int owner = -1;
    int n0    = 0;
    int dcy   = 0;
    int ptr   = 0;

    always @(negedge i_clock) begin
        logic [1:0] e_grant, e_done;
        logic       e_busy, e_tick;
        int         w;
        e_grant = 2'b00;
        e_done  = 2'b00;
        e_busy  = 1'b0;
        e_tick  = 1'b0;
        if (!i_reset_n) begin
            owner = -1;
            ptr   = 0;
        end else if (owner >= 0) begin
            e_grant = (owner == 1) ? 2'b10 : 2'b01;
            e_busy  = 1'b1;
            if (cyc == dcy) e_done = e_grant;
            e_tick = (cyc < dcy) && (((cyc - n0) % P) == 0);
        end
        chk($sformatf("model grant cyc%0d", cyc), o_grant, e_grant);
        chk($sformatf("model done cyc%0d", cyc), o_done, e_done);
        chk($sformatf("model busy cyc%0d", cyc), {1'b0, o_busy}, {1'b0, e_busy});
        chk($sformatf("model tick cyc%0d", cyc), {1'b0, o_tick}, {1'b0, e_tick});
        if (i_reset_n) begin
            if (owner < 0) begin
                if (i_req != 2'b00) begin
                    w     = i_req[ptr] ? ptr : 1 - ptr;
                    owner = w;
                    n0    = cyc;
                    dcy   = cyc + 1 + P * int'((w == 1) ? i_len1 : i_len0);
                end
            end else if (cyc == dcy) begin
                ptr   = 1 - owner;
                owner = -1;
            end else if (!i_req[owner] && cyc != dcy - 1) begin
                ptr   = 1 - owner;
                owner = -1;
            end
        end
        cyc++;
    end

    task automatic adv(input int k);
        repeat (k) @(posedge i_clock);
        #2;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        adv(2);
        i_reset_n = 1'b1;
        adv(1);
    endtask

    initial begin
        adv(3);
        i_reset_n = 1'b1;
        adv(1);
        chk("reset grant", o_grant, 2'b00);
        chk("reset done", o_done, 2'b00);
        chk("reset busy", {1'b0, o_busy}, 2'b00);
        chk("reset tick", {1'b0, o_tick}, 2'b00);

        // len0=3: ticks at N+4/8/12, done at N+13; len change mid-run ignored
        i_len0 = 16'd3;
        i_req  = 2'b01;
        adv(1);
        chk("A grant N+1", o_grant, 2'b01);
        chk("A busy N+1", {1'b0, o_busy}, 2'b01);
        adv(1);
        i_len0 = 16'd7;
        adv(2);
        chk("A tick N+4", {1'b0, o_tick}, 2'b01);
        adv(4);
        chk("A tick N+8", {1'b0, o_tick}, 2'b01);
        adv(4);
        chk("A tick N+12", {1'b0, o_tick}, 2'b01);
        chk("A no done N+12", o_done, 2'b00);
        adv(1);
        chk("A done N+13", o_done, 2'b01);
        chk("A grant N+13", o_grant, 2'b01);
        i_req = 2'b00;
        adv(1);
        chk("A idle busy", {1'b0, o_busy}, 2'b00);
        chk("A idle grant", o_grant, 2'b00);

        // len0=0: grant and done together at N+1
        i_len0 = 16'd0;
        i_req  = 2'b01;
        adv(1);
        chk("B grant N+1", o_grant, 2'b01);
        chk("B done N+1", o_done, 2'b01);
        i_req = 2'b00;
        adv(1);
        chk("B busy N+2", {1'b0, o_busy}, 2'b00);

        // Both requesting after reset: 0 first, then strict alternation
        do_reset();
        i_len0 = 16'd2;
        i_len1 = 16'd2;
        i_req  = 2'b11;
        adv(1);
        chk("C grant0 N+1", o_grant, 2'b01);
        adv(8);
        chk("C done0 N+9", o_done, 2'b01);
        adv(1);
        chk("C idle N+10", {1'b0, o_busy}, 2'b00);
        adv(1);
        chk("C grant1 N+11", o_grant, 2'b10);
        adv(8);
        chk("C done1 N+19", o_done, 2'b10);
        adv(2);
        chk("C grant0 N+21", o_grant, 2'b01);
        adv(8);
        chk("C done0 N+29", o_done, 2'b01);
        i_req = 2'b00;
        adv(2);

        // req1 len1=5 aborted at N+6 while req0 toggles; pointer then back to 0
        i_len1 = 16'd5;
        i_req  = 2'b10;
        adv(2);
        i_req = 2'b11;
        adv(1);
        i_req = 2'b10;
        chk("D grant1 N+3", o_grant, 2'b10);
        adv(3);
        i_req = 2'b00;
        adv(1);
        chk("D busy N+7", {1'b0, o_busy}, 2'b00);
        chk("D grant N+7", o_grant, 2'b00);
        chk("D done N+7", o_done, 2'b00);
        i_len0 = 16'd0;
        i_len1 = 16'd0;
        i_req  = 2'b11;
        adv(1);
        chk("D ptr grant0", o_grant, 2'b01);
        chk("D ptr done0", o_done, 2'b01);
        i_req = 2'b00;
        adv(2);

        // Drop on the expiring tick: done still issued
        i_len0 = 16'd1;
        i_req  = 2'b01;
        adv(4);
        chk("E tick N+4", {1'b0, o_tick}, 2'b01);
        chk("E no done N+4", o_done, 2'b00);
        i_req = 2'b00;
        adv(1);
        chk("E done N+5", o_done, 2'b01);
        adv(1);

        // Async reset mid-run clears outputs at once; requester 0 wins afterwards
        i_len0 = 16'd4;
        i_req  = 2'b01;
        adv(3);
        i_reset_n = 1'b0;
        #1;
        chk("F rst grant", o_grant, 2'b00);
        chk("F rst done", o_done, 2'b00);
        chk("F rst busy", {1'b0, o_busy}, 2'b00);
        chk("F rst tick", {1'b0, o_tick}, 2'b00);
        i_req = 2'b00;
        adv(2);
        i_reset_n = 1'b1;
        i_len0    = 16'd1;
        i_len1    = 16'd1;
        i_req     = 2'b11;
        adv(1);
        chk("F grant0", o_grant, 2'b01);
        adv(4);
        chk("F done0", o_done, 2'b01);
        i_req = 2'b00;
        adv(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
